// File: rtl/regressor_pkg.sv
// Shared constants and types for the linear-regressor datapath: operand widths,
// the Q56.8 fraction width and the sample sequencer state encoding.
package regressor_pkg;

    localparam int unsigned X_W      = 32;
    localparam int unsigned Y_W      = 64;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned Q_FRAC_W = 8;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        EMIT = 3'd2,
        REL  = 3'd3,
        DONE = 3'd4
    } state_e;

    // Two's-complement step of the sweep; overflow wraps silently.
    function automatic logic [X_W-1:0] x_advance(input logic [X_W-1:0] x,
                                                 input logic [X_W-1:0] step);
        return x + step;
    endfunction

endpackage

// File: rtl/func_sample_gen_if.sv
// Bundles the func request/response handshake and the (x, y) sample stream
// between the sample sequencer (master) and its neighbours (slave).
interface func_sample_gen_if;
    import regressor_pkg::*;

    logic           start_func;
    logic [X_W-1:0] x_out;
    logic [Y_W-1:0] y_in;
    logic           func_done;
    logic           func_ovf;
    logic           smp_valid;
    logic           smp_ready;
    logic [X_W-1:0] smp_x;
    logic [Y_W-1:0] smp_y;
    logic           smp_last;

    modport master (
        output start_func, x_out, smp_valid, smp_x, smp_y, smp_last,
        input  y_in, func_done, func_ovf, smp_ready
    );

    modport slave (
        input  start_func, x_out, smp_valid, smp_x, smp_y, smp_last,
        output y_in, func_done, func_ovf, smp_ready
    );

endinterface

// File: rtl/func_sample_gen.sv
// Sweeps x over x_start + k*x_step, requests func for each x and streams (x, y).
// Optional request watchdog enabled by defining FUNC_SAMPLE_TIMEOUT_EN.
module func_sample_gen
    import regressor_pkg::*;
`ifdef FUNC_SAMPLE_TIMEOUT_EN
    #(parameter int unsigned TIMEOUT_CYCLES = 32'd64)
`endif
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [X_W-1:0]          x_start,
    input  logic [X_W-1:0]          x_step,
    input  logic [CNT_W-1:0]        n_samples,
    output logic                    busy,
    output logic                    done,
    output logic                    ovf_sticky,
    output logic                    err,
    func_sample_gen_if.master       bus
);

    state_e           state_q, state_d;
    logic [X_W-1:0]   x_step_q, x_step_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [X_W-1:0]   x_out_q, x_out_d;
    logic             start_func_q, start_func_d;
    logic             smp_valid_q, smp_valid_d;
    logic [X_W-1:0]   smp_x_q, smp_x_d;
    logic [Y_W-1:0]   smp_y_q, smp_y_d;
    logic             smp_last_q, smp_last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;

`ifdef FUNC_SAMPLE_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0]  wdog_q, wdog_d;
    logic             err_q, err_d;
`endif

    // Next-state and next-output logic of the sweep sequencer.
    always_comb begin
        state_d      = state_q;
        x_step_d     = x_step_q;
        n_d          = n_q;
        cnt_d        = cnt_q;
        x_out_d      = x_out_q;
        start_func_d = start_func_q;
        smp_valid_d  = smp_valid_q;
        smp_x_d      = smp_x_q;
        smp_y_d      = smp_y_q;
        smp_last_d   = smp_last_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        ovf_d        = ovf_q;
`ifdef FUNC_SAMPLE_TIMEOUT_EN
        wdog_d       = wdog_q;
        err_d        = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    x_step_d = x_step;
                    n_d      = n_samples;
                    cnt_d    = {CNT_W{1'b0}};
                    x_out_d  = x_start;
                    ovf_d    = 1'b0;
                    busy_d   = 1'b1;
`ifdef FUNC_SAMPLE_TIMEOUT_EN
                    err_d    = 1'b0;
                    wdog_d   = {WD_W{1'b0}};
`endif
                    if (n_samples == {CNT_W{1'b0}}) begin
                        state_d = DONE;
                    end else begin
                        state_d      = REQ;
                        start_func_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (bus.func_done) begin
                    smp_x_d      = x_out_q;
                    smp_y_d      = bus.y_in;
                    ovf_d        = ovf_q | bus.func_ovf;
                    smp_last_d   = (cnt_q == (n_q - CNT_ONE));
                    start_func_d = 1'b0;
                    smp_valid_d  = 1'b1;
                    state_d      = EMIT;
`ifdef FUNC_SAMPLE_TIMEOUT_EN
                end else if (wdog_q == WD_LAST) begin
                    err_d        = 1'b1;
                    start_func_d = 1'b0;
                    state_d      = DONE;
                end else begin
                    wdog_d = wdog_q + {{(WD_W-1){1'b0}}, 1'b1};
                end
`else
                end else begin
                    state_d = REQ;
                end
`endif
            end
            EMIT: begin
                // Sample fields stay frozen until the consumer accepts.
                if (bus.smp_ready) begin
                    smp_valid_d = 1'b0;
                    if (smp_last_q) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                        x_out_d = x_advance(x_out_q, x_step_q);
                        state_d = REL;
                    end
                end else begin
                    state_d = EMIT;
                end
            end
            REL: begin
                if (!bus.func_done) begin
                    state_d      = REQ;
                    start_func_d = 1'b1;
`ifdef FUNC_SAMPLE_TIMEOUT_EN
                    wdog_d       = {WD_W{1'b0}};
`endif
                end else begin
                    state_d = REL;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d      = IDLE;
                start_func_d = 1'b0;
                smp_valid_d  = 1'b0;
                busy_d       = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears every flop immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            x_step_q     <= {X_W{1'b0}};
            n_q          <= {CNT_W{1'b0}};
            cnt_q        <= {CNT_W{1'b0}};
            x_out_q      <= {X_W{1'b0}};
            start_func_q <= 1'b0;
            smp_valid_q  <= 1'b0;
            smp_x_q      <= {X_W{1'b0}};
            smp_y_q      <= {Y_W{1'b0}};
            smp_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
`ifdef FUNC_SAMPLE_TIMEOUT_EN
            wdog_q       <= {WD_W{1'b0}};
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            x_step_q     <= x_step_d;
            n_q          <= n_d;
            cnt_q        <= cnt_d;
            x_out_q      <= x_out_d;
            start_func_q <= start_func_d;
            smp_valid_q  <= smp_valid_d;
            smp_x_q      <= smp_x_d;
            smp_y_q      <= smp_y_d;
            smp_last_q   <= smp_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ovf_q        <= ovf_d;
`ifdef FUNC_SAMPLE_TIMEOUT_EN
            wdog_q       <= wdog_d;
            err_q        <= err_d;
`endif
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign ovf_sticky     = ovf_q;
    assign bus.start_func = start_func_q;
    assign bus.x_out      = x_out_q;
    assign bus.smp_valid  = smp_valid_q;
    assign bus.smp_x      = smp_x_q;
    assign bus.smp_y      = smp_y_q;
    assign bus.smp_last   = smp_last_q;
`ifdef FUNC_SAMPLE_TIMEOUT_EN
    assign err            = err_q;
`else
    assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_func_sample_gen.sv
// Scoreboard bench for func_sample_gen with a stub func (3-cycle latency,
// y = x + 5, done released 2 cycles after the request drops).
module tb_func_sample_gen;
    import regressor_pkg::*;

    typedef struct {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic           last;
    } smp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [X_W-1:0]   x_start = '0;
    logic [X_W-1:0]   x_step = '0;
    logic [CNT_W-1:0] n_samples = '0;
    logic             busy, done, ovf_sticky, err;

    func_sample_gen_if bus();

    func_sample_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .x_start    (x_start),
        .x_step     (x_step),
        .n_samples  (n_samples),
        .busy       (busy),
        .done       (done),
        .ovf_sticky (ovf_sticky),
        .err        (err),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    int   popped = 0;
    int   done_cnt = 0;
    int   sf_cnt = 0;
    int   valid_cnt = 0;
    smp_t sb_q[$];
    bit   stub_hang = 1'b0;
    bit   stub_ovf_first = 1'b0;
    int   lat_cnt, rel_cnt, stub_idx;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [X_W-1:0] x, input logic [Y_W-1:0] y, input logic last);
        smp_t e;
        e.x = x; e.y = y; e.last = last;
        sb_q.push_back(e);
    endtask

    // Stub func evaluator.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.func_done <= 1'b0;
            bus.func_ovf  <= 1'b0;
            bus.y_in      <= '0;
            lat_cnt       <= 0;
            rel_cnt       <= 0;
            stub_idx      <= 0;
        end else begin
            if (start && !busy) stub_idx <= 0;
            if (bus.start_func && !bus.func_done && !stub_hang) begin
                if (lat_cnt == 2) begin
                    bus.func_done <= 1'b1;
                    bus.y_in      <= {{(Y_W-X_W){bus.x_out[X_W-1]}}, bus.x_out} + 64'd5;
                    bus.func_ovf  <= stub_ovf_first && (stub_idx == 0);
                    lat_cnt       <= 0;
                    stub_idx      <= stub_idx + 1;
                end else begin
                    lat_cnt <= lat_cnt + 1;
                end
            end else if (!bus.start_func && bus.func_done) begin
                if (rel_cnt == 1) begin
                    bus.func_done <= 1'b0;
                    bus.func_ovf  <= 1'b0;
                    rel_cnt       <= 0;
                end else begin
                    rel_cnt <= rel_cnt + 1;
                end
            end
        end
    end

    // Scoreboard monitor and event counters.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (bus.start_func) sf_cnt++;
        if (bus.smp_valid) valid_cnt++;
        if (rst_n && bus.smp_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_sample", {63'd0, bus.smp_valid}, 64'd0);
            end else if (bus.smp_ready) begin
                smp_t e;
                e = sb_q.pop_front();
                popped++;
                chk("smp_x", {32'd0, bus.smp_x}, {32'd0, e.x});
                chk("smp_y", bus.smp_y, e.y);
                chk("smp_last", {63'd0, bus.smp_last}, {63'd0, e.last});
            end else begin
                chk("stall_x", {32'd0, bus.smp_x}, {32'd0, sb_q[0].x});
                chk("stall_y", bus.smp_y, sb_q[0].y);
                chk("stall_start_func", {63'd0, bus.start_func}, 64'd0);
            end
        end
    end

    task automatic pulse_start(input logic [X_W-1:0] xs, input logic [X_W-1:0] st,
                               input logic [CNT_W-1:0] n);
        x_start = xs; x_step = st; n_samples = n;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (done) begin seen = 1'b1; break; end
        end
        if (!seen) chk({name, "_done_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_busy"}, {63'd0, busy}, 64'd0);
        chk({name, "_done"}, {63'd0, done}, 64'd0);
        chk({name, "_ovf"}, {63'd0, ovf_sticky}, 64'd0);
        chk({name, "_err"}, {63'd0, err}, 64'd0);
        chk({name, "_start_func"}, {63'd0, bus.start_func}, 64'd0);
        chk({name, "_x_out"}, {32'd0, bus.x_out}, 64'd0);
        chk({name, "_smp_valid"}, {63'd0, bus.smp_valid}, 64'd0);
        chk({name, "_smp_x"}, {32'd0, bus.smp_x}, 64'd0);
        chk({name, "_smp_y"}, bus.smp_y, 64'd0);
        chk({name, "_smp_last"}, {63'd0, bus.smp_last}, 64'd0);
    endtask

    initial begin
        int cyc;
        bit seen;
        bus.smp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic sweep (3,8), (5,10), (7,12).
        push(32'd3, 64'd8, 1'b0); push(32'd5, 64'd10, 1'b0); push(32'd7, 64'd12, 1'b1);
        popped = 0; done_cnt = 0;
        pulse_start(32'd3, 32'd2, 16'd3);
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        wait_done("basic");
        chk("basic_busy_at_done", {63'd0, busy}, 64'd0);
        chk("basic_ovf", {63'd0, ovf_sticky}, 64'd0);
        chk("basic_err", {63'd0, err}, 64'd0);
        @(posedge clk); #1;
        chk("basic_done_one_cycle", {63'd0, done}, 64'd0);
        chk("basic_done_count", done_cnt, 64'd1);
        chk("basic_popped", popped, 64'd3);

        // Empty sweep: done two cycles after start, no request, no sample.
        sf_cnt = 0; valid_cnt = 0;
        x_start = 32'd9; x_step = 32'd1; n_samples = 16'd0;
        start = 1'b1; cyc = 0; seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (done) begin seen = 1'b1; break; end
        end
        chk("empty_done_seen", {63'd0, seen}, 64'd1);
        chk("empty_done_latency", cyc, 64'd2);
        chk("empty_start_func", sf_cnt, 64'd0);
        chk("empty_valid", valid_cnt, 64'd0);

        // Back-pressure on the second sample for 10 cycles.
        push(32'd10, 64'd15, 1'b0); push(32'd13, 64'd18, 1'b0); push(32'd16, 64'd21, 1'b1);
        popped = 0;
        pulse_start(32'd10, 32'd3, 16'd3);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (popped == 1) begin seen = 1'b1; break; end
        end
        chk("stall_first_pop", {63'd0, seen}, 64'd1);
        bus.smp_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (bus.smp_valid) begin seen = 1'b1; break; end
        end
        chk("stall_second_valid", {63'd0, seen}, 64'd1);
        repeat (10) @(posedge clk);
        #1;
        bus.smp_ready = 1'b1;
        wait_done("stall");
        chk("stall_popped", popped, 64'd3);

        // Overflow on the first sample only; cleared by the next start.
        stub_ovf_first = 1'b1;
        push(32'd0, 64'd5, 1'b0); push(32'd1, 64'd6, 1'b1);
        pulse_start(32'd0, 32'd1, 16'd2);
        wait_done("ovf");
        chk("ovf_sticky_at_done", {63'd0, ovf_sticky}, 64'd1);
        stub_ovf_first = 1'b0;
        push(32'd10, 64'd15, 1'b1);
        pulse_start(32'd10, 32'd1, 16'd1);
        chk("ovf_cleared_by_start", {63'd0, ovf_sticky}, 64'd0);
        wait_done("ovf2");
        chk("ovf2_at_done", {63'd0, ovf_sticky}, 64'd0);

        // Signed wrap of x.
        popped = 0;
        push(32'h7FFF_FFFF, 64'h0000_0000_8000_0004, 1'b0);
        push(32'h8000_0000, 64'hFFFF_FFFF_8000_0005, 1'b1);
        pulse_start(32'h7FFF_FFFF, 32'd1, 16'd2);
        wait_done("wrap");
        chk("wrap_popped", popped, 64'd2);

        // Asynchronous reset while a sample is pending.
        push(32'd20, 64'd25, 1'b0);
        bus.smp_ready = 1'b0;
        pulse_start(32'd20, 32'd1, 16'd2);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (bus.smp_valid) begin seen = 1'b1; break; end
        end
        chk("rst_emit_reached", {63'd0, seen}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        sb_q.delete();
        bus.smp_ready = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        valid_cnt = 0; sf_cnt = 0;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_valid", valid_cnt, 64'd0);
        chk("post_rst_start_func", sf_cnt, 64'd0);
        chk("post_rst_busy", {63'd0, busy}, 64'd0);

`ifdef FUNC_SAMPLE_TIMEOUT_EN
        // Watchdog: func never completes.
        stub_hang = 1'b1;
        sf_cnt = 0; valid_cnt = 0;
        pulse_start(32'd4, 32'd1, 16'd1);
        wait_done("timeout");
        chk("timeout_err", {63'd0, err}, 64'd1);
        chk("timeout_req_cycles", sf_cnt, 64'd64);
        chk("timeout_valid", valid_cnt, 64'd0);
        stub_hang = 1'b0;
        push(32'd1, 64'd6, 1'b1);
        pulse_start(32'd1, 32'd1, 16'd1);
        chk("timeout_err_cleared", {63'd0, err}, 64'd0);
        wait_done("after_timeout");
`endif

        chk("scoreboard_empty", sb_q.size(), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
